xs3_serial_sched: RTL and testbench
===================================

Name: xs3_serial_sched

Overview:
Round-robin scheduler that shares one serial BCD-to-excess-3 converter between NREQ requesters. It grants one requester at a time and serialises that requester's 4-bit BCD digit LSB-first onto the converter's serial input. It then captures the converter's 4-bit result, checks it against digit+3, and returns it with a per-requester ack pulse. It sits between the digit producers (display and counter logic) and the converter.

Parameters:
NREQ, 4, number of requesters (2..8)
CAP_DELAY, 1, cycles from the 4th serial bit's cycle to the conv_z capture edge (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request, held until its ack
digit  input  4*NREQ  BCD digit for requester i at bits [4i+3:4i]
ack  output  NREQ  one-cycle pulse to the serviced requester
res_valid  output  1  one-cycle pulse, result fields valid
res_data  output  4  captured excess-3 code (0 when rejected)
res_id  output  clog2(NREQ)  index of the serviced requester
res_err  output  1  invalid BCD input or converter mismatch
busy  output  1  high in every state except IDLE
ser_x  output  1  serial bit to the converter
frame_sync  output  1  high during bit-0 cycle of a frame
conv_z  input  4  parallel excess-3 output from the converter

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; last_grant = NREQ-1, so req[0] wins first; shift register, counters and id cleared.
- States: IDLE, SHIFT, WAIT, DONE.
- IDLE:
  - If any req is high, grant the first asserted index searching from last_grant+1 upward, with modulo-NREQ wrap.
  - Latch the digit and id into registers.
  - Digit <= 9: go to SHIFT with bit count 0.
  - Digit > 9: go directly to DONE with reject flag set. No frame is sent.
  - No req: stay in IDLE.
- SHIFT: exactly 4 cycles.
  - ser_x = shift_reg[0] in each cycle; shift right at the end of each cycle.
  - frame_sync = 1 only in the bit-0 cycle.
  - After the bit-3 cycle, go to WAIT.
- WAIT: CAP_DELAY cycles.
  - conv_z is sampled into the result register on the clock edge that ends the last WAIT cycle.
  - Then go to DONE.
- DONE: one cycle.
  - res_valid = 1, ack[id] = 1, res_id = id.
  - res_data = captured conv_z, or 0 if rejected.
  - res_err = rejected OR (captured conv_z != latched digit + 4'd3).
  - last_grant <= id. Next state is IDLE.
- Outputs outside their states:
  - ser_x = 0 and frame_sync = 0 outside SHIFT.
  - ack, res_valid and res_err are 0 outside DONE.
  - res_data and res_id hold their last value.
- Latency with CAP_DELAY=1: the grant happens in an IDLE cycle; ack comes 6 cycles after that grant cycle (4 SHIFT + 1 WAIT + DONE). Reject latency is 1 cycle.
- A new grant is possible in the IDLE cycle right after DONE, so sustained throughput is one digit per 7 cycles.
- Requests and digits:
  - Dropping req after grant does not abort; the result is still posted and acked.
  - Changing digit after grant has no effect.
  - A req that is high in the same cycle as its own ack is treated as a new request in the following IDLE.
- Arithmetic: digit+3 is computed 4-bit; the max is 9+3 = 12, so no overflow.
- Reset mid-frame: operation aborted, no ack issued, ser_x forced to 0 immediately; the requester must re-request.

Test Plan:
- req[0]=1, digit0=5, bench converter model returns 8 -> frame_sync in first SHIFT cycle; ser_x = 1,0,1,0; ack[0], res_valid, res_data=8, res_id=0, res_err=0 exactly 6 cycles after grant.
- req[0] and req[2] held continuously -> service order 0,2,0,2; each ack[i] single-cycle; busy low exactly one cycle between frames.
- digit1=12 on req[1] -> ack[1] and res_valid one cycle after grant; res_err=1, res_data=0; no frame_sync, ser_x stays 0.
- Converter model forced to return 7 for digit 5 -> res_data=7, res_err=1, ack still issued.
- Boundary digits 0 and 9 -> res_data 3 and 12, res_err=0; CAP_DELAY=3 build shifts ack 2 cycles later.
- rst asserted during SHIFT bit 2 -> all outputs 0 within that cycle; after release, pending req[0] is serviced first with a full 4-bit frame.

Source files
------------

// File: rtl/xs3_serial_sched.sv
`default_nettype none
// ============================================================================
//  Module   : xs3_serial_sched
//  Purpose  : Round-robin scheduler sharing one serial BCD-to-excess-3
//             converter between NREQ requesters. Serialises the granted
//             digit LSB-first, captures the converter result, checks it
//             against digit+3 and returns it with a per-requester ack.
//  Revision : 1.0  initial release
// ============================================================================
module xs3_serial_sched #(
    parameter int NREQ      = 4,
    parameter int CAP_DELAY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [4*NREQ-1:0]         digit,
    output logic [NREQ-1:0]           ack,
    output logic                      res_valid,
    output logic [3:0]                res_data,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic                      res_err,
    output logic                      busy,
    output logic                      ser_x,
    output logic                      frame_sync,
    input  logic [3:0]                conv_z
);

    localparam int IDW = $clog2(NREQ);
    localparam int WCW = (CAP_DELAY > 1) ? $clog2(CAP_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;
    logic [3:0]       cur_digit;
    logic [2:0]       shift_reg;   // bits still to be sent after the one on ser_x
    logic [1:0]       bit_cnt;
    logic [WCW-1:0]   wait_cnt;

    logic             grant_valid;
    logic [IDW-1:0]   grant_id;
    logic [3:0]       grant_digit;
    int               idx;

    // Round-robin search starting one past the last serviced requester
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_digit = '0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = IDW'(idx);
                grant_digit = digit[4*idx +: 4];
            end
        end
    end

    // Scheduler FSM; every output is registered and pulses default low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDW'(NREQ - 1);
            cur_id     <= '0;
            cur_digit  <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            ser_x      <= 1'b0;
            frame_sync <= 1'b0;
            ack        <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            res_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ser_x      <= 1'b0;
            frame_sync <= 1'b0;
            ack        <= '0;
            res_valid  <= 1'b0;
            res_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_id    <= grant_id;
                        cur_digit <= grant_digit;
                        busy      <= 1'b1;
                        if (grant_digit > 4'd9) begin
                            // Non-BCD digit: skip the converter, reject at once
                            state         <= DONE;
                            ack[grant_id] <= 1'b1;
                            res_valid     <= 1'b1;
                            res_id        <= grant_id;
                            res_data      <= '0;
                            res_err       <= 1'b1;
                        end else begin
                            state      <= SHIFT;
                            ser_x      <= grant_digit[0];
                            shift_reg  <= grant_digit[3:1];
                            frame_sync <= 1'b1;
                            bit_cnt    <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 2'd3) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        ser_x     <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[2:1]};
                        bit_cnt   <= bit_cnt + 2'd1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WCW'(CAP_DELAY - 1)) begin
                        state       <= DONE;
                        ack[cur_id] <= 1'b1;
                        res_valid   <= 1'b1;
                        res_id      <= cur_id;
                        res_data    <= conv_z;
                        res_err     <= (conv_z != cur_digit + 4'd3);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= cur_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xs3_serial_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xs3_serial_sched
//  Purpose  : Directed self-checking bench for xs3_serial_sched with a
//             behavioural serial BCD-to-excess-3 converter model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xs3_serial_sched;

    localparam int NREQ      = 4;
    localparam int CAP_DELAY = 1;
    localparam int LAT       = 5 + CAP_DELAY;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [4*NREQ-1:0]    digit;
    logic [NREQ-1:0]      ack;
    logic                 res_valid;
    logic [3:0]           res_data;
    logic [1:0]           res_id;
    logic                 res_err;
    logic                 busy;
    logic                 ser_x;
    logic                 frame_sync;
    logic [3:0]           conv_z;

    int checks   = 0;
    int failures = 0;

    xs3_serial_sched #(.NREQ(NREQ), .CAP_DELAY(CAP_DELAY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .digit      (digit),
        .ack        (ack),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
        .busy       (busy),
        .ser_x      (ser_x),
        .frame_sync (frame_sync),
        .conv_z     (conv_z)
    );

    always #5 clk = ~clk;

    // Converter model: deserialise LSB-first frame, output value+3 (+bias)
    logic [3:0] m_sh;
    logic [2:0] m_n;
    logic [3:0] bias;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sh <= '0;
            m_n  <= '0;
        end else if (frame_sync) begin
            m_sh <= {ser_x, 3'b000};
            m_n  <= 3'd1;
        end else if (m_n != 3'd0 && m_n < 3'd4) begin
            m_sh <= {ser_x, m_sh[3:1]};
            m_n  <= m_n + 3'd1;
        end
    end
    assign conv_z = m_sh + 4'd3 + bias;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the grant cycle; runs until res_valid (bounded) and checks the result
    task automatic do_frame(input string name, input int id, input logic [3:0] data,
                            input logic err, input logic [3:0] bits_exp,
                            input logic framed, input int lat);
        int         n;
        int         fs_cnt;
        logic       fs_first;
        logic       busy_ok;
        logic [3:0] sb;
        chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        chk({name, "_ack_idle"}, {28'd0, ack}, 32'd0);
        n = 0; fs_cnt = 0; fs_first = 1'b0; busy_ok = 1'b1; sb = 4'd0;
        do begin
            tick();
            n++;
            if (frame_sync) begin
                fs_cnt++;
                if (n == 1) fs_first = 1'b1;
            end
            if (n <= 4) sb[n-1] = ser_x;
            if (!busy) busy_ok = 1'b0;
        end while (!res_valid && n < 20);
        chk({name, "_latency"}, n, lat);
        chk({name, "_ack"}, {28'd0, ack}, 32'd1 << id);
        chk({name, "_res_id"}, {30'd0, res_id}, id);
        chk({name, "_res_data"}, {28'd0, res_data}, {28'd0, data});
        chk({name, "_res_err"}, {31'd0, res_err}, {31'd0, err});
        chk({name, "_fs_count"}, fs_cnt, framed ? 1 : 0);
        chk({name, "_fs_bit0"}, {31'd0, fs_first}, {31'd0, framed});
        chk({name, "_ser_bits"}, {28'd0, sb}, {28'd0, bits_exp});
        chk({name, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req = '0; digit = '0; bias = 4'd0;
        tick(); tick();
        // Reset state
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {28'd0, res_data}, 32'd0);
        chk("rst_res_id", {30'd0, res_id}, 32'd0);
        chk("rst_res_err", {31'd0, res_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ser_x", {31'd0, ser_x}, 32'd0);
        chk("rst_frame_sync", {31'd0, frame_sync}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_noreq_busy", {31'd0, busy}, 32'd0);

        // Digit 5 on requester 0 -> 8, bits 1,0,1,0
        req = 4'b0001; digit[3:0] = 4'd5;
        do_frame("d5", 0, 4'd8, 1'b0, 4'b0101, 1'b1, LAT);
        req = 4'b0000;
        tick();
        chk("post_ack", {28'd0, ack}, 32'd0);
        chk("post_valid", {31'd0, res_valid}, 32'd0);
        chk("post_hold_data", {28'd0, res_data}, 32'd8);
        chk("post_hold_id", {30'd0, res_id}, 32'd0);

        // Non-BCD digit 12 on requester 1 -> immediate reject
        req = 4'b0010; digit[7:4] = 4'd12;
        do_frame("rej", 1, 4'd0, 1'b1, 4'b0000, 1'b0, 1);
        req = 4'b0000;
        tick();

        // Boundary digit 9 on requester 3 -> 12
        req = 4'b1000; digit[15:12] = 4'd9;
        do_frame("d9", 3, 4'd12, 1'b0, 4'b1001, 1'b1, LAT);
        req = 4'b0000;
        tick();

        // Requesters 0 and 2 held: service order 0,2,0,2
        req = 4'b0101; digit[3:0] = 4'd2; digit[11:8] = 4'd6;
        do_frame("rr0a", 0, 4'd5, 1'b0, 4'b0010, 1'b1, LAT);
        tick();
        do_frame("rr2a", 2, 4'd9, 1'b0, 4'b0110, 1'b1, LAT);
        tick();
        do_frame("rr0b", 0, 4'd5, 1'b0, 4'b0010, 1'b1, LAT);
        tick();
        do_frame("rr2b", 2, 4'd9, 1'b0, 4'b0110, 1'b1, LAT);
        req = 4'b0000;
        tick();

        // Boundary digit 0 on requester 2 -> 3
        req = 4'b0100; digit[11:8] = 4'd0;
        do_frame("d0", 2, 4'd3, 1'b0, 4'b0000, 1'b1, LAT);
        req = 4'b0000;
        tick();

        // Faulty converter returns 7 for digit 5
        bias = 4'd15;
        req = 4'b0001; digit[3:0] = 4'd5;
        do_frame("mis", 0, 4'd7, 1'b1, 4'b0101, 1'b1, LAT);
        req = 4'b0000;
        tick();
        bias = 4'd0;

        // Reset during SHIFT bit 2 of digit 6 (bit2 = 1)
        req = 4'b0001; digit[3:0] = 4'd6;
        tick(); tick(); tick();
        chk("pre_rst_ser_x", {31'd0, ser_x}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_x", {31'd0, ser_x}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_fs", {31'd0, frame_sync}, 32'd0);
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        chk("mid_rst_res_data", {28'd0, res_data}, 32'd0);
        req = 4'b0101; digit[11:8] = 4'd4;
        tick();
        rst = 1'b0;
        // Without reset requester 2 would win; after reset requester 0 goes first
        do_frame("post_rst", 0, 4'd9, 1'b0, 4'b0110, 1'b1, LAT);
        req = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
